// File: rtl/dft_pkg.sv
// Shared types and constants for the DFT bin sequencer and its coefficient table.
package dft_pkg;

    typedef enum logic [2:0] {
        S_FILL,
        S_LAUNCH,
        S_WAIT,
        S_EMIT,
        S_GAP
    } seq_state_t;

    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

    // Address width for n entries, never less than 1 bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dft_coef_table.sv
// NBINS x SIZE coefficient register array: guarded write port, registered row read.
module dft_coef_table
    import dft_pkg::*;
#(
    parameter int unsigned SIZE  = 28,
    parameter int unsigned NBINS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [clog2(NBINS)-1:0] wr_bin,
    input  logic [clog2(SIZE)-1:0]  wr_idx,
    input  logic [31:0]             wr_data,
    input  logic [clog2(NBINS)-1:0] rd_bin,
    output logic [31:0]             rd_row [0:SIZE-1]
);

    logic [31:0] mem [0:NBINS-1][0:SIZE-1];
    logic        wr_ok;

    // Out-of-range addresses are dropped rather than aliased.
    assign wr_ok = wr_en && (32'(wr_bin) < NBINS) && (32'(wr_idx) < SIZE);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < int'(NBINS); b++) begin
                for (int i = 0; i < int'(SIZE); i++) begin
                    mem[b][i] <= '0;
                end
            end
            for (int i = 0; i < int'(SIZE); i++) begin
                rd_row[i] <= '0;
            end
        end else begin
            if (wr_ok) begin
                mem[wr_bin][wr_idx] <= wr_data;
            end
            for (int i = 0; i < int'(SIZE); i++) begin
                rd_row[i] <= mem[rd_bin][i];
            end
        end
    end

endmodule

// File: rtl/dft_bin_sequencer.sv
// Collects one frame of fp32 samples and launches the weighted-sum engine once per bin.
// Optional watchdog in WAIT enabled by defining DFT_SEQ_TIMEOUT_EN (adds the sticky err port).
module dft_bin_sequencer
    import dft_pkg::*;
#(
    parameter int unsigned SIZE  = 28,
    parameter int unsigned NBINS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [31:0]             s_data,
    input  logic                    coef_we,
    input  logic [clog2(NBINS)-1:0] coef_bin,
    input  logic [clog2(SIZE)-1:0]  coef_idx,
    input  logic [31:0]             coef_data,
    output logic [31:0]             ws_data   [0:SIZE-1],
    output logic [31:0]             ws_weight [0:SIZE-1],
    output logic                    ws_dataIn,
    input  logic                    ws_dataOut,
    input  logic [31:0]             ws_result,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [31:0]             m_data,
    output logic [clog2(NBINS)-1:0] m_bin,
    output logic                    m_last,
`ifdef DFT_SEQ_TIMEOUT_EN
    output logic                    err,
`endif
    output logic                    busy
);

    localparam int unsigned CW = clog2(SIZE);
    localparam int unsigned BW = clog2(NBINS);

    seq_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bin_q, bin_d;
    logic          s_hs;
    logic          cap;
    logic          last_bin;
    logic          coef_ok;

`ifdef DFT_SEQ_TIMEOUT_EN
    localparam int unsigned TIMEOUT = 4096;
    logic [15:0] wdog_q;
    logic        tmo;
`endif

    assign s_hs     = s_valid & s_ready;
    assign last_bin = (bin_q == BW'(NBINS - 1));
    assign coef_ok  = coef_we & (state_q == S_FILL);

    dft_coef_table #(
        .SIZE  (SIZE),
        .NBINS (NBINS)
    ) u_coef (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (coef_ok),
        .wr_bin  (coef_bin),
        .wr_idx  (coef_idx),
        .wr_data (coef_data),
        .rd_bin  (bin_q),
        .rd_row  (ws_weight)
    );

    // Next-state and capture decisions.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        cap     = 1'b0;
`ifdef DFT_SEQ_TIMEOUT_EN
        tmo     = 1'b0;
`endif
        case (state_q)
            S_FILL: begin
                if (s_hs) begin
                    if (cnt_q == CW'(SIZE - 1)) begin
                        cnt_d   = '0;
                        bin_d   = '0;
                        state_d = S_LAUNCH;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT: begin
                if (ws_dataOut) begin
                    cap     = 1'b1;
                    state_d = S_EMIT;
                end
`ifdef DFT_SEQ_TIMEOUT_EN
                else if (wdog_q == 16'(TIMEOUT - 1)) begin
                    cap     = 1'b1;
                    tmo     = 1'b1;
                    state_d = S_EMIT;
                end
`endif
            end
            S_EMIT: begin
                if (m_ready) begin
                    if (last_bin) begin
                        state_d = S_FILL;
                    end else begin
                        bin_d   = bin_q + BW'(1);
                        state_d = S_GAP;
                    end
                end
            end
            // Hold off relaunch until the engine has dropped done.
            S_GAP: begin
                if (!ws_dataOut) begin
                    state_d = S_LAUNCH;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FILL;
            cnt_q     <= '0;
            bin_q     <= '0;
            s_ready   <= 1'b0;
            busy      <= 1'b0;
            ws_dataIn <= 1'b0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_bin     <= '0;
            m_last    <= 1'b0;
            for (int i = 0; i < int'(SIZE); i++) begin
                ws_data[i] <= '0;
            end
`ifdef DFT_SEQ_TIMEOUT_EN
            wdog_q    <= '0;
            err       <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bin_q     <= bin_d;
            s_ready   <= (state_d == S_FILL);
            busy      <= (state_d != S_FILL);
            ws_dataIn <= (state_d == S_WAIT);
            m_valid   <= (state_d == S_EMIT);
            if ((state_q == S_FILL) && s_hs) begin
                ws_data[cnt_q] <= s_data;
            end
            if (cap) begin
                m_data <= ws_result;
                m_bin  <= bin_q;
                m_last <= last_bin;
            end
`ifdef DFT_SEQ_TIMEOUT_EN
            wdog_q <= ((state_q == S_WAIT) && (state_d == S_WAIT)) ? wdog_q + 16'd1 : 16'd0;
            if (tmo) begin
                m_data <= FP_QNAN;
                err    <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_dft_bin_sequencer.sv
// Directed bench for dft_bin_sequencer (SIZE=4, NBINS=2) with a behavioural fp32 engine.
module tb_dft_bin_sequencer;

    localparam int unsigned SIZE  = 4;
    localparam int unsigned NBINS = 2;

    localparam logic [31:0] F_0P5 = 32'h3F000000;
    localparam logic [31:0] F_1   = 32'h3F800000;
    localparam logic [31:0] F_1P5 = 32'h3FC00000;
    localparam logic [31:0] F_2   = 32'h40000000;
    localparam logic [31:0] F_3   = 32'h40400000;
    localparam logic [31:0] F_4   = 32'h40800000;
    localparam logic [31:0] F_5   = 32'h40A00000;
    localparam logic [31:0] F_M1  = 32'hBF800000;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        coef_we;
    logic [0:0]  coef_bin;
    logic [1:0]  coef_idx;
    logic [31:0] coef_data;
    logic [31:0] ws_data   [0:SIZE-1];
    logic [31:0] ws_weight [0:SIZE-1];
    logic        ws_dataIn;
    logic        ws_dataOut;
    logic [31:0] ws_result;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [0:0]  m_bin;
    logic        m_last;
    logic        busy;
`ifdef DFT_SEQ_TIMEOUT_EN
    logic        err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    int eng_lat  = 10;
    int eng_hold = 0;
    bit eng_on   = 1'b1;

    always #5 clk = ~clk;

    dft_bin_sequencer #(
        .SIZE  (SIZE),
        .NBINS (NBINS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .coef_we    (coef_we),
        .coef_bin   (coef_bin),
        .coef_idx   (coef_idx),
        .coef_data  (coef_data),
        .ws_data    (ws_data),
        .ws_weight  (ws_weight),
        .ws_dataIn  (ws_dataIn),
        .ws_dataOut (ws_dataOut),
        .ws_result  (ws_result),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_bin      (m_bin),
        .m_last     (m_last),
`ifdef DFT_SEQ_TIMEOUT_EN
        .err        (err),
`endif
        .busy       (busy)
    );

    // fp32 <-> real for normal values and zero (enough for these vectors).
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == 31'd0) return 0.0;
        d = {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] eng_compute();
        real acc;
        acc = 0.0;
        for (int i = 0; i < int'(SIZE); i++) begin
            acc = acc + f2r(ws_data[i]) * f2r(ws_weight[i]);
        end
        return r2f(acc);
    endfunction

    // Engine model: raises done eng_lat cycles after start, holds it eng_hold cycles after start falls.
    initial begin
        int lat;
        int hold_cnt;
        lat        = 0;
        hold_cnt   = 0;
        ws_dataOut = 1'b0;
        ws_result  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!ws_dataIn) begin
                lat = 0;
                if (ws_dataOut) begin
                    if (hold_cnt > 0) hold_cnt--;
                    else ws_dataOut = 1'b0;
                end
            end else if (!ws_dataOut && eng_on) begin
                lat++;
                if (lat >= eng_lat) begin
                    ws_result  = eng_compute();
                    ws_dataOut = 1'b1;
                    hold_cnt   = eng_hold;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic coef_write(input int b, input int i, input logic [31:0] d);
        coef_we   = 1'b1;
        coef_bin  = 1'(b);
        coef_idx  = 2'(i);
        coef_data = d;
        @(negedge clk);
        coef_we   = 1'b0;
    endtask

    task automatic load_row(input int b, input logic [31:0] w);
        for (int i = 0; i < int'(SIZE); i++) coef_write(b, i, w);
    endtask

    task automatic send(input logic [31:0] d);
        int n;
        n       = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            bound_fail("s_ready");
            s_valid = 1'b0;
            return;
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [3:0][31:0] smp, input bit chk);
        for (int i = 0; i < int'(SIZE); i++) send(smp[i]);
        if (chk) begin
            check("launch_t1_low", 32'(ws_dataIn), 32'd0);
            @(negedge clk);
            check("launch_t2_high", 32'(ws_dataIn), 32'd1);
            check("busy_launch", 32'(busy), 32'd1);
        end
    endtask

    task automatic wait_start(input string name);
        int n;
        n = 0;
        while (!ws_dataIn && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ws_dataIn) bound_fail(name);
    endtask

    task automatic collect(input string name, input logic [31:0] ed, input logic eb, input logic el);
        int n;
        n = 0;
        while (!m_valid && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (!m_valid) begin
            bound_fail(name);
            return;
        end
        check({name, "_data"}, m_data, ed);
        check({name, "_bin"}, 32'(m_bin), 32'(eb));
        check({name, "_last"}, 32'(m_last), 32'(el));
        check({name, "_start_low"}, 32'(ws_dataIn), 32'd0);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    typedef struct packed {
        logic [3:0][31:0] smp;
        logic [31:0]      w0;
        logic [31:0]      w1;
        logic [31:0]      e0;
        logic [31:0]      e1;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2,
                                input logic [31:0] s3, input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] e0, input logic [31:0] e1);
        vec_t v;
        v.smp = {s3, s2, s1, s0};
        v.w0  = w0;
        v.w1  = w1;
        v.e0  = e0;
        v.e1  = e1;
        return v;
    endfunction

    initial begin
        vec_t             vecs [4];
        logic [3:0][31:0] std_frame;
        int               drop_at;
        int               rise_at;
        int               extra;
        bit               overlap;

        std_frame = {F_4, F_3, F_2, F_1};
        vecs[0] = mk(F_1, F_2, F_3, F_4, F_1,   F_2,   32'h41200000, 32'h41A00000);
        vecs[1] = mk(F_1, F_2, F_3, F_4, F_0P5, 32'd0, 32'h40A00000, 32'h00000000);
        vecs[2] = mk(F_2, F_2, F_2, F_2, F_1,   F_4,   32'h41000000, 32'h42000000);
        vecs[3] = mk(F_1, F_1, F_1, F_1, F_M1,  F_1P5, 32'hC0800000, 32'h40C00000);

        rst       = 1'b1;
        s_valid   = 1'b0;
        s_data    = '0;
        coef_we   = 1'b0;
        coef_bin  = '0;
        coef_idx  = '0;
        coef_data = '0;
        m_ready   = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", m_data, 32'd0);
        check("rst_m_bin", 32'(m_bin), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_ws_dataIn", 32'(ws_dataIn), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ws_data0", ws_data[0], 32'd0);
        check("rst_ws_weight0", ws_weight[0], 32'd0);
`ifdef DFT_SEQ_TIMEOUT_EN
        check("rst_err", 32'(err), 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_s_ready", 32'(s_ready), 32'd1);

        // Table-driven frames.
        for (int v = 0; v < 4; v++) begin
            load_row(0, vecs[v].w0);
            load_row(1, vecs[v].w1);
            send_frame(vecs[v].smp, v == 0);
            collect($sformatf("vec%0d_b0", v), vecs[v].e0, 1'b0, 1'b0);
            collect($sformatf("vec%0d_b1", v), vecs[v].e1, 1'b1, 1'b1);
        end

        // Backpressure on bin 0.
        load_row(0, F_1);
        load_row(1, F_2);
        send_frame(std_frame, 1'b0);
        extra = 0;
        while (!m_valid && extra < 100) begin
            @(negedge clk);
            extra++;
        end
        if (!m_valid) bound_fail("bp_first");
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("bp_m_valid", 32'(m_valid), 32'd1);
            check("bp_m_data", m_data, 32'h41200000);
            check("bp_start_low", 32'(ws_dataIn), 32'd0);
        end
        collect("bp_b0", 32'h41200000, 1'b0, 1'b0);
        collect("bp_b1", 32'h41A00000, 1'b1, 1'b1);

        // Engine holds done after start falls.
        eng_hold = 5;
        send_frame(std_frame, 1'b0);
        collect("hold_b0", 32'h41200000, 1'b0, 1'b0);
        drop_at = -1;
        rise_at = -1;
        overlap = 1'b0;
        for (int c = 0; c < 40 && rise_at < 0; c++) begin
            if (ws_dataIn && ws_dataOut) overlap = 1'b1;
            if (drop_at < 0 && !ws_dataOut) drop_at = c;
            if (ws_dataIn) rise_at = c;
            else @(negedge clk);
        end
        check("hold_no_overlap", 32'(overlap), 32'd0);
        check("hold_rise_after_drop",
              32'((drop_at >= 0) && (rise_at - drop_at >= 1) && (rise_at - drop_at <= 2)), 32'd1);
        collect("hold_b1", 32'h41A00000, 1'b1, 1'b1);
        extra = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (m_valid || ws_dataIn) extra++;
        end
        check("hold_two_results", 32'(extra), 32'd0);
        eng_hold = 0;

        // Reset pulse while waiting on bin 0.
        send_frame(std_frame, 1'b0);
        wait_start("rstw_start");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstw_start_low", 32'(ws_dataIn), 32'd0);
        check("rstw_m_valid", 32'(m_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        load_row(0, F_1);
        load_row(1, F_2);
        send_frame(std_frame, 1'b0);
        collect("rstw_b0", 32'h41200000, 1'b0, 1'b0);
        collect("rstw_b1", 32'h41A00000, 1'b1, 1'b1);

        // Coefficient writes outside FILL are ignored.
        send_frame(std_frame, 1'b0);
        wait_start("wewait_start");
        coef_write(0, 0, F_5);
        coef_write(1, 1, F_5);
        collect("wewait_b0", 32'h41200000, 1'b0, 1'b0);
        collect("wewait_b1", 32'h41A00000, 1'b1, 1'b1);

        // Coefficient write together with the final sample handshake is accepted.
        for (int i = 0; i < 3; i++) send(std_frame[i]);
        coef_we   = 1'b1;
        coef_bin  = 1'b0;
        coef_idx  = 2'd3;
        coef_data = F_2;
        send(std_frame[3]);
        coef_we   = 1'b0;
        collect("welast_b0", 32'h41600000, 1'b0, 1'b0);
        collect("welast_b1", 32'h41A00000, 1'b1, 1'b1);

`ifdef DFT_SEQ_TIMEOUT_EN
        // Engine never answers bin 0.
        load_row(0, F_1);
        eng_on = 1'b0;
        send_frame(std_frame, 1'b0);
        collect("tmo_b0", 32'h7FC00000, 1'b0, 1'b0);
        check("tmo_err", 32'(err), 32'd1);
        eng_on = 1'b1;
        collect("tmo_b1", 32'h41A00000, 1'b1, 1'b1);
        check("tmo_err_sticky", 32'(err), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dft_bin_sequencer.md
# dft_bin_sequencer

Front-end controller that drives the weighted-sum engine for one DFT frame. It collects `SIZE` IEEE-754 single-precision samples from a valid/ready stream into a frame buffer and holds an `NBINS` x `SIZE` coefficient table. It then launches the engine once per bin, presenting the frame and that bin's coefficient row with a `dataIn` pulse, and waits for `dataOut`. Each captured result goes out on a valid/ready output stream tagged with its bin index.

## Interface
Parameters:
- `SIZE`, 28: samples per frame; engine lane count.
- `NBINS`, 8: bins per frame; rows in the coefficient table.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `s_valid` in 1, `s_ready` out 1, `s_data` in 32: sample input stream.
- `coef_we` in 1: coefficient write strobe.
- `coef_bin` in clog2(NBINS): row to write.
- `coef_idx` in clog2(SIZE): column to write.
- `coef_data` in 32: coefficient value.
- `ws_data[0:SIZE-1]` out 32 each: frame buffer, to engine `data`.
- `ws_weight[0:SIZE-1]` out 32 each: current coefficient row, to engine `weight`.
- `ws_dataIn` out 1: engine start level.
- `ws_dataOut` in 1: engine done.
- `ws_result` in 32: engine sum.
- `m_valid` out 1, `m_ready` in 1, `m_data` out 32: result output stream.
- `m_bin` out clog2(NBINS): bin index of `m_data`.
- `m_last` out 1: high with the result of bin `NBINS-1`.
- `busy` out 1: high in any state except FILL.

## Operation
- FSM states: FILL, LAUNCH, WAIT, EMIT, GAP.
- **FILL**
  - `s_ready`=1.
  - Each `s_valid&s_ready` handshake writes `s_data` to buffer[cnt] and increments `cnt`.
  - On the handshake with `cnt==SIZE-1`: clear `cnt` and `bin`, go to LAUNCH.
- **LAUNCH**: drive `ws_dataIn`=1, go to WAIT.
- **WAIT**
  - `ws_dataIn` stays 1.
  - On the first cycle with `ws_dataOut`=1: register `ws_result` into `m_data`, `bin` into `m_bin`, and `(bin==NBINS-1)` into `m_last`.
  - Then go to EMIT.
- **EMIT**
  - `ws_dataIn`=0, `m_valid`=1.
  - On `m_ready`: if this was the last bin, go to FILL; otherwise increment `bin` and go to GAP.
- **GAP**
  - `ws_dataIn`=0.
  - Wait until `ws_dataOut`=0, with a minimum of 1 cycle, then go to LAUNCH. This guarantees a fresh rising edge for the engine.
- `ws_weight` = `coef[bin]`, driven from a register. `ws_data` and `ws_weight` never change while `ws_dataIn`=1.
- Coefficient writes:
  - Accepted only in FILL; ignored in every other state.
  - A write addressing `coef_bin>=NBINS` or `coef_idx>=SIZE` is ignored.
- No arithmetic is done on the data; all values pass through bit-exact.

## Timing
- Reset values:
  - `s_ready`=0 during reset, 1 the cycle after.
  - `m_valid`=0, `m_data`=0, `m_bin`=0, `m_last`=0.
  - `ws_dataIn`=0, `busy`=0.
  - Buffer and coefficient table are cleared to 0.
- Last sample handshake at cycle t: `ws_dataIn` rises at t+2.
- `ws_dataOut` seen at cycle w: `m_valid` is high at w+1 and `ws_dataIn` is low at w+1.
- If `m_ready` is held high, bin-to-bin spacing is engine latency + 4 cycles.
- `m_valid` holds and `m_data` is stable until `m_ready`. Backpressure never re-raises `ws_dataIn`.
- `ws_dataOut`=1 already present on entry to WAIT, left over from the previous bin: cannot occur, because GAP waits it out.
- `rst` mid-frame: aborts to FILL, discards partial frame and pending result, drops `ws_dataIn` the next cycle.
- Coefficient write in the same cycle as the final sample handshake: the write is accepted, since the state is still FILL.

## Configuration
- `DFT_SEQ_TIMEOUT_EN` defined:
  - Adds a 16-bit watchdog in WAIT and localparam `TIMEOUT`=4096.
  - If `ws_dataOut` has not arrived after `TIMEOUT` cycles: output 32'h7FC00000 (qNaN) as the result, set sticky output `err`=1, proceed as normal.
  - `err` is cleared only by `rst`.
- Undefined: no watchdog and no `err` port; WAIT waits indefinitely.

## Structure
- Shared package `dft_pkg`:
  - FSM state enum `seq_state_t`.
  - Constant `FP_QNAN`=32'h7FC00000.
  - Function `clog2`.
- Sub-module `dft_coef_table`: NBINS x SIZE register array with a guarded write port and a registered row-read by `bin`.

## Test plan
- SIZE=4, NBINS=2.
  - Stimulus: samples 1.0, 2.0, 3.0, 4.0 (3F800000, 40000000, 40400000, 40800000); row0 all 1.0, row1 all 2.0; behavioural engine with latency 10.
  - Required: `m_data` 41200000 (10.0) with `m_bin`=0, then 41A00000 (20.0) with `m_bin`=1 and `m_last`=1.
- `m_ready` held low 20 cycles on bin 0: `m_data` stays 41200000; `ws_dataIn` stays low; bin 1 is not launched.
- Engine keeps `dataOut` high 5 cycles after `dataIn` falls: next `ws_dataIn` rises 1 cycle after `dataOut` drops; exactly 2 results are emitted.
- `rst` pulsed in WAIT of bin 0: `ws_dataIn`=0 and `m_valid`=0 the next cycle; a fresh frame yields correct results.
- `coef_we` during WAIT: table unchanged; results match the pre-write coefficients.
- With `DFT_SEQ_TIMEOUT_EN`, engine never responds: after 4096 cycles `m_data`=7FC00000 and `err`=1; bin 1 proceeds.
